// File: rtl/mic_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module : mic_reg_pkg (package)
// Purpose: Shared types and constants for the MIC register bank.
//          - DEFAULT_WIDTH : default datapath width.
//          - word_t        : signed datapath word.
//          - MAR..H        : register indices of the MIC-style register file.
//          - onehot()      : one-hot write/inc/dec mask from a register index.
// Revision: 1.0 - initial release
// ============================================================================
package mic_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef logic signed [DEFAULT_WIDTH-1:0] word_t;

  // Register indices of the MIC datapath
  localparam int MAR = 0;
  localparam int MDR = 1;
  localparam int PC  = 2;
  localparam int MBR = 3;
  localparam int SP  = 4;
  localparam int LV  = 5;
  localparam int CPP = 6;
  localparam int TOS = 7;
  localparam int OPC = 8;
  localparam int H   = 9;

  // One-hot mask sized for the largest legal bank (64 registers).
  // Callers truncate to NUM_REGS bits.
  function automatic logic [63:0] onehot(input int unsigned idx);
    logic [63:0] m;
    m = '0;
    if (idx < 64) m[idx] = 1'b1;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mic_reg_cell.sv
`default_nettype none
// ============================================================================
// Module : mic_reg_cell
// Purpose: One WIDTH-bit register with update priority
//          reset > C-bus write > inc/dec > hold.
//          Increment and decrement wrap modulo 2^WIDTH.
// Ports  : clk, reset  - clock, synchronous active-high reset
//          c_in        - C-bus data
//          wr, inc, dec- per-cell write / increment / decrement strobes
//          q           - stored value
//          conflict    - high when inc and dec are both requested without a
//                        write this cycle (the register holds)
// Revision: 1.0 - initial release
// ============================================================================
module mic_reg_cell
  import mic_reg_pkg::*;
#(
  parameter int                 WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] c_in,
  input  logic             wr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             conflict
);

  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_val_q;
  logic [WIDTH-1:0] w_val_d;

  always_comb begin
    w_val_d  = r_val_q;
    conflict = 1'b0;
    if (wr) begin
      w_val_d = c_in;
    end else if (inc ^ dec) begin
      w_val_d = inc ? (r_val_q + c_ONE) : (r_val_q - c_ONE);
    end else if (inc && dec) begin
      conflict = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_val_q <= RESET_VAL;
    else       r_val_q <= w_val_d;
  end

  assign q = r_val_q;

endmodule
`default_nettype wire

// File: rtl/mic_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : mic_reg_bank
// Purpose: NUM_REGS x WIDTH register bank with multi-hot C-bus write,
//          in-place inc/dec, and two independent muxed read buses (A, B)
//          with valid flags. No tristates.
// Ports  : clk, reset          - clock, synchronous active-high reset
//          c_in, c_wr_mask     - C-bus data and multi-hot write mask
//          inc_mask, dec_mask  - per-register increment / decrement
//          a_en, a_sel         - bus A enable and register select
//          b_en, b_sel         - bus B enable and register select
//          a_out, a_valid      - bus A data / data-valid
//          b_out, b_valid      - bus B data / data-valid
//          conflict_err        - sticky: some register saw inc and dec
//                                together without a write; cleared by reset
// Option : MIC_REG_BANK_BYPASS_EN - when defined, a C-bus write to the
//          register selected on a bus is forwarded to that bus in the same
//          cycle. Inc/dec results are never forwarded.
// Revision: 1.0 - initial release
// ============================================================================
module mic_reg_bank
  import mic_reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               NUM_REGS  = 16,
  parameter int               SEL_W     = $clog2(NUM_REGS),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] c_in,
  input  logic [NUM_REGS-1:0]     c_wr_mask,
  input  logic [NUM_REGS-1:0]     inc_mask,
  input  logic [NUM_REGS-1:0]     dec_mask,
  input  logic                    a_en,
  input  logic [SEL_W-1:0]        a_sel,
  input  logic                    b_en,
  input  logic [SEL_W-1:0]        b_sel,
  output logic signed [WIDTH-1:0] a_out,
  output logic                    a_valid,
  output logic signed [WIDTH-1:0] b_out,
  output logic                    b_valid,
  output logic                    conflict_err
);

  logic [WIDTH-1:0]    w_regs [NUM_REGS];
  logic [NUM_REGS-1:0] w_conflict;
  logic                r_conflict_q;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
      mic_reg_cell #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_cell (
        .clk      (clk),
        .reset    (reset),
        .c_in     (c_in),
        .wr       (c_wr_mask[gi]),
        .inc      (inc_mask[gi]),
        .dec      (dec_mask[gi]),
        .q        (w_regs[gi]),
        .conflict (w_conflict[gi])
      );
    end
  endgenerate

  // Read muxes: a select matching no register (only possible when NUM_REGS
  // is not a power of two) leaves the bus at zero with valid low.
  always_comb begin
    a_out   = '0;
    a_valid = 1'b0;
    b_out   = '0;
    b_valid = 1'b0;
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (a_en && (a_sel == SEL_W'(i))) begin
          a_valid = 1'b1;
`ifdef MIC_REG_BANK_BYPASS_EN
          a_out   = c_wr_mask[i] ? c_in : w_regs[i];
`else
          a_out   = w_regs[i];
`endif
        end
        if (b_en && (b_sel == SEL_W'(i))) begin
          b_valid = 1'b1;
`ifdef MIC_REG_BANK_BYPASS_EN
          b_out   = c_wr_mask[i] ? c_in : w_regs[i];
`else
          b_out   = w_regs[i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_conflict_q <= 1'b0;
    else       r_conflict_q <= r_conflict_q | (|w_conflict);
  end

  assign conflict_err = r_conflict_q;

endmodule
`default_nettype wire

// File: tb/tb_mic_reg_bank.sv
`default_nettype none
// ============================================================================
// Module : tb_mic_reg_bank
// Purpose: Directed self-checking bench for mic_reg_bank. A 16-register
//          instance carries the main sequence; a 10-register instance
//          sharing the same stimulus covers out-of-range selects.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mic_reg_bank;
  import mic_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic signed [31:0] c_in;
  logic [15:0] c_wr_mask, inc_mask, dec_mask;
  logic        a_en, b_en;
  logic [3:0]  a_sel, b_sel;

  logic signed [31:0] a_out, b_out, a_out10, b_out10;
  logic        a_valid, b_valid, conflict_err;
  logic        a_valid10, b_valid10, conflict_err10;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mic_reg_bank #(.WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .c_in(c_in),
    .c_wr_mask(c_wr_mask), .inc_mask(inc_mask), .dec_mask(dec_mask),
    .a_en(a_en), .a_sel(a_sel), .b_en(b_en), .b_sel(b_sel),
    .a_out(a_out), .a_valid(a_valid), .b_out(b_out), .b_valid(b_valid),
    .conflict_err(conflict_err)
  );

  mic_reg_bank #(.WIDTH(32), .NUM_REGS(10)) dut10 (
    .clk(clk), .reset(reset), .c_in(c_in),
    .c_wr_mask(c_wr_mask[9:0]), .inc_mask(inc_mask[9:0]), .dec_mask(dec_mask[9:0]),
    .a_en(a_en), .a_sel(a_sel), .b_en(b_en), .b_sel(b_sel),
    .a_out(a_out10), .a_valid(a_valid10), .b_out(b_out10), .b_valid(b_valid10),
    .conflict_err(conflict_err10)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] m;

  initial begin
    reset = 1'b1; c_in = 32'h1234; c_wr_mask = 16'hFFFF;
    inc_mask = '0; dec_mask = '0;
    a_en = 1'b1; b_en = 1'b1; a_sel = 4'd0; b_sel = 4'd1;

    // Reset: outputs forced low while reset is high
    tick();
    chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
    chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
    chk("rst_a_out", a_out, 32'd0);
    tick();
    reset = 1'b0; c_wr_mask = '0; c_in = '0;
    #1;
    for (int i = 0; i < 16; i++) begin
      a_sel = 4'(i);
      #1;
      chk($sformatf("rst_reg%0d", i), a_out, 32'd0);
    end
    chk("rst_conflict", {31'd0, conflict_err}, 32'd0);

    // Multi-hot write, dual read
    tick();
    c_wr_mask = 16'h0011; c_in = 32'hDEAD_BEEF;
    tick();
    c_wr_mask = '0;
    a_sel = 4'd0; b_sel = 4'd4; #1;
    chk("mw_a0", a_out, 32'hDEAD_BEEF);
    chk("mw_b4", b_out, 32'hDEAD_BEEF);
    chk("mw_a_valid", {31'd0, a_valid}, 32'd1);
    chk("mw_b_valid", {31'd0, b_valid}, 32'd1);
    a_sel = 4'd1; #1;
    chk("mw_a1", a_out, 32'd0);
    a_sel = 4'd4; b_sel = 4'd4; #1;
    chk("same_sel_a", a_out, 32'hDEAD_BEEF);
    chk("same_sel_b", b_out, 32'hDEAD_BEEF);

    // Increment wrap
    tick();
    m = onehot(PC); c_wr_mask = m[15:0]; c_in = 32'hFFFF_FFFF;
    tick();
    c_wr_mask = '0; inc_mask = m[15:0];
    tick();
    inc_mask = '0; a_sel = 4'd2; #1;
    chk("inc_wrap", a_out, 32'd0);

    // Decrement wrap
    m = onehot(MBR); dec_mask = m[15:0];
    tick();
    dec_mask = '0; a_sel = 4'd3; #1;
    chk("dec_wrap", a_out, 32'hFFFF_FFFF);

    // Write beats inc
    c_wr_mask = 16'h0004; inc_mask = 16'h0004; c_in = 32'd5;
    tick();
    c_wr_mask = '0; inc_mask = '0; a_sel = 4'd2; #1;
    chk("wr_beats_inc", a_out, 32'd5);

    // Plain inc then dec
    inc_mask = 16'h0004;
    tick();
    inc_mask = '0; #1;
    chk("inc_plain", a_out, 32'd6);
    dec_mask = 16'h0004;
    tick();
    dec_mask = '0; #1;
    chk("dec_plain", a_out, 32'd5);

    // Conflict: inc and dec together on reg1
    chk("pre_conflict", {31'd0, conflict_err}, 32'd0);
    c_wr_mask = 16'h0002; c_in = 32'd7;
    tick();
    c_wr_mask = '0; inc_mask = 16'h0002; dec_mask = 16'h0002;
    tick();
    inc_mask = '0; dec_mask = '0; a_sel = 4'd1; #1;
    chk("conflict_hold", a_out, 32'd7);
    chk("conflict_set", {31'd0, conflict_err}, 32'd1);
    tick(); tick();
    chk("conflict_sticky", {31'd0, conflict_err}, 32'd1);

    // Disabled read
    a_en = 1'b0; a_sel = 4'd0; #1;
    chk("dis_a_out", a_out, 32'd0);
    chk("dis_a_valid", {31'd0, a_valid}, 32'd0);
    a_en = 1'b1; #1;
    chk("en_a_valid", {31'd0, a_valid}, 32'd1);

    // Out-of-range select on the 10-register bank
    a_sel = 4'd12; #1;
    chk("oor_a_out", a_out10, 32'd0);
    chk("oor_a_valid", {31'd0, a_valid10}, 32'd0);
    a_sel = 4'd4; #1;
    chk("ir10_a_out", a_out10, 32'hDEAD_BEEF);
    chk("ir10_a_valid", {31'd0, a_valid10}, 32'd1);

    // Same-cycle read during C-bus write to reg5 (LV)
    tick();
    m = onehot(LV); c_wr_mask = m[15:0]; c_in = 32'h0000_00AA; a_sel = 4'd5; #1;
`ifdef MIC_REG_BANK_BYPASS_EN
    chk("bypass_same", a_out, 32'h0000_00AA);
`else
    chk("bypass_same", a_out, 32'd0);
`endif
    tick();
    c_wr_mask = '0; #1;
    chk("bypass_after", a_out, 32'h0000_00AA);

    // Reset overrides a same-cycle write and clears the sticky flag
    reset = 1'b1; c_wr_mask = 16'h0020; c_in = 32'h55; #1;
    chk("rst_force_out", a_out, 32'd0);
    tick();
    reset = 1'b0; c_wr_mask = '0; #1;
    chk("rst2_reg5", a_out, 32'd0);
    chk("rst2_conflict", {31'd0, conflict_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
